// File: rtl/datapath_pkg.sv
// Shared constants for the register-file/ALU datapath: opcodes, flag bit
// positions and default sizes.
package datapath_pkg;

  localparam int WIDTH  = 16;
  localparam int NREGS  = 16;
  localparam int NFLAGS = 5;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_SUBC = 8'h0A;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MOV  = 8'h0D;
  localparam logic [7:0] OP_LSH  = 8'h84;
  localparam logic [7:0] OP_RSH  = 8'h8C;

  localparam int FLG_C = 4;
  localparam int FLG_L = 3;
  localparam int FLG_F = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 0;

endpackage

// File: rtl/datapath_core_alu.sv
// Combinational ALU: produces the result, candidate flag values and a mask
// of which flags this opcode is allowed to update.
module alu
  import datapath_pkg::*;
#(
  parameter int WIDTH = datapath_pkg::WIDTH
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [7:0]        opcode,
  input  logic              c_in,
  output logic [WIDTH-1:0]  r,
  output logic [NFLAGS-1:0] flg_nxt,
  output logic [NFLAGS-1:0] flg_upd
);

  logic             cin;
  logic [WIDTH:0]   ext;

  always_comb begin
    r       = '0;
    flg_nxt = '0;
    flg_upd = '0;
    ext     = '0;
    cin     = c_in & ((opcode == OP_ADDC) | (opcode == OP_SUBC));
    case (opcode)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_ADD, OP_ADDU, OP_ADDC: begin
        ext            = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        r              = ext[WIDTH-1:0];
        flg_nxt[FLG_C] = ext[WIDTH];
        flg_nxt[FLG_F] = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        flg_upd[FLG_C] = 1'b1;
        flg_upd[FLG_F] = (opcode != OP_ADDU);
      end
      OP_SUB, OP_SUBC: begin
        // bit WIDTH of the modulo-2^(WIDTH+1) difference is the borrow
        ext            = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(cin);
        r              = ext[WIDTH-1:0];
        flg_nxt[FLG_C] = ext[WIDTH];
        flg_nxt[FLG_F] = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        flg_upd[FLG_C] = 1'b1;
        flg_upd[FLG_F] = 1'b1;
      end
      OP_CMP: begin
        flg_nxt[FLG_Z] = (a == b);
        flg_nxt[FLG_L] = (a < b);
        flg_nxt[FLG_N] = ($signed(a) < $signed(b));
        flg_upd[FLG_Z] = 1'b1;
        flg_upd[FLG_L] = 1'b1;
        flg_upd[FLG_N] = 1'b1;
      end
      OP_MOV: r = b;
      OP_LSH: r = a << b[3:0];
      OP_RSH: r = a >> b[3:0];
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_core.sv
// Register file + ALU datapath: operand muxes, gated write-back to one/multi-hot
// selected registers, and the registered status flag word.
module datapath_core
  import datapath_pkg::*;
#(
  parameter int WIDTH = datapath_pkg::WIDTH,
  parameter int NREGS = datapath_pkg::NREGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  immediate,
  input  logic [NREGS-1:0]  enable,
  input  logic [7:0]        opcode,
  input  logic [4:0]        control1,
  input  logic [4:0]        control2,
  input  logic              imm_control,
  input  logic              buff_en,
  output logic [WIDTH-1:0]  bus_out,
  output logic [NFLAGS-1:0] flags,
  input  logic [3:0]        dbg_sel,
  output logic [WIDTH-1:0]  dbg_data
);

  localparam int SELW = $clog2(NREGS);

  logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [NFLAGS-1:0]           flags_q, flags_d;

  logic [WIDTH-1:0]  a_op, b_op, alu_r;
  logic [NFLAGS-1:0] flg_nxt, flg_upd, flg_upd_eff;
  logic              wr_en;

  // select codes at or above NREGS read as constant zero
  always_comb begin
    a_op = (control1 < 5'(NREGS)) ? regs_q[control1[SELW-1:0]] : '0;
    if (imm_control)
      b_op = immediate;
    else
      b_op = (control2 < 5'(NREGS)) ? regs_q[control2[SELW-1:0]] : '0;
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .a       (a_op),
    .b       (b_op),
    .opcode  (opcode),
    .c_in    (flags_q[FLG_C]),
    .r       (alu_r),
    .flg_nxt (flg_nxt),
    .flg_upd (flg_upd)
  );

  assign wr_en       = buff_en && (opcode != OP_CMP);
  // CMP is a status-only op, so it is not gated by buff_en
  assign flg_upd_eff = (buff_en || (opcode == OP_CMP)) ? flg_upd : '0;

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      for (int i = 0; i < NREGS; i++)
        if (enable[i]) regs_d[i] = alu_r;
    end
  end

  always_comb begin
    flags_d = flags_q;
    for (int i = 0; i < NFLAGS; i++)
      if (flg_upd_eff[i]) flags_d[i] = flg_nxt[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q  <= '0;
      flags_q <= '0;
    end else begin
      regs_q  <= regs_d;
      flags_q <= flags_d;
    end
  end

  assign bus_out  = buff_en ? alu_r : '0;
  assign flags    = flags_q;
  assign dbg_data = regs_q[dbg_sel[SELW-1:0]];

endmodule
